// File: rtl/dram_uart_loader_if.sv
// DRAM write port driven by the UART boot loader.
interface dram_uart_loader_if;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_wren;

  modport master (output mem_addr, output mem_data, output mem_wren);
  modport slave  (input  mem_addr, input  mem_data, input  mem_wren);
endinterface

// File: rtl/dram_uart_loader.sv
// UART (8N1) boot loader: writes DEPTH received bytes sequentially into DRAM,
// then releases the processor and stays idle until reset.
//
// state   | meaning
// IDLE    | waiting for a start edge while load_en is high
// START   | half-bit wait, confirm start bit still low
// DATA    | sampling 8 data bits, LSB first
// STOP    | sampling stop bit; low stop flags a framing error
// WRITE   | single-cycle DRAM write, advance count
// DONE    | image complete, processor enabled, inputs ignored
module dram_uart_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 256
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic                      rx,
  input  logic                      load_en,
  dram_uart_loader_if.master        mem,
  output logic                      proc_en,
  output logic                      load_done,
  output logic                      frame_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WRITE, S_DONE
  } state_t;

  localparam int              TW      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]   T_FULL  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]   T_HALF  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [8:0]      DEPTH_C = 9'(DEPTH);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [8:0]    count_q, count_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          wren_q, wren_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;
  logic          timer_exp;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wren_q    <= 1'b0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wren_q    <= wren_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
    end
  end

  assign timer_exp = (timer_q == '0);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    count_d   = count_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wren_d    = 1'b0;
    done_d    = done_q;
    ferr_d    = ferr_q;
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;

    case (state_q)
      S_IDLE: begin
        if (load_en && !rx_s_q) begin
          timer_d = T_HALF;
          state_d = S_START;
        end
      end
      S_START: begin
        if (timer_exp) begin
          if (!rx_s_q) begin
            timer_d   = T_FULL;
            bit_idx_d = '0;
            state_d   = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_DATA: begin
        if (timer_exp) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          timer_d = T_FULL;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_STOP: begin
        if (timer_exp) begin
          if (rx_s_q) begin
            // Address/data are registered here so they are stable for the whole strobe.
            addr_d  = count_q[7:0];
            data_d  = shift_q;
            wren_d  = 1'b1;
            state_d = S_WRITE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_WRITE: begin
        count_d = count_q + 9'd1;
        if (count_q + 9'd1 == DEPTH_C) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem.mem_addr = addr_q;
  assign mem.mem_data = data_q;
  assign mem.mem_wren = wren_q;
  assign proc_en      = done_q;
  assign load_done    = done_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_dram_uart_loader.sv
// Directed bench for dram_uart_loader: DEPTH=4 instance for functional cases,
// DEPTH=256 instance for the full-image boundary.
module tb_dram_uart_loader;
  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst;
  logic rx4, rx256, le4, le256;
  logic pe4, ld4, fe4, pe256, ld256, fe256;

  dram_uart_loader_if bus4();
  dram_uart_loader_if bus256();

  dram_uart_loader #(.CLKS_PER_BIT(CPB), .DEPTH(4)) u_dut4 (
    .CLK(clk), .rst(rst), .rx(rx4), .load_en(le4), .mem(bus4),
    .proc_en(pe4), .load_done(ld4), .frame_err(fe4));

  dram_uart_loader #(.CLKS_PER_BIT(CPB), .DEPTH(256)) u_dut256 (
    .CLK(clk), .rst(rst), .rx(rx256), .load_en(le256), .mem(bus256),
    .proc_en(pe256), .load_done(ld256), .frame_err(fe256));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] wa4[$], wd4[$], wa256[$], wd256[$];
  int         wc4[$];
  int         wlong4 = 0;
  int         done_cyc4 = -1;
  int         pe_cyc4 = -1;
  logic       wren4_prev = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (bus4.mem_wren) begin
      wa4.push_back(bus4.mem_addr);
      wd4.push_back(bus4.mem_data);
      wc4.push_back(cyc);
      if (wren4_prev) wlong4 = wlong4 + 1;
    end
    wren4_prev = bus4.mem_wren;
    if (ld4 && done_cyc4 < 0) done_cyc4 = cyc;
    if (pe4 && pe_cyc4 < 0) pe_cyc4 = cyc;
    if (bus256.mem_wren) begin
      wa256.push_back(bus256.mem_addr);
      wd256.push_back(bus256.mem_data);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input bit big, input logic v);
    if (big) rx256 = v;
    else     rx4 = v;
  endtask

  task automatic send_frame(input bit big, input logic [7:0] b, input logic stop_bit,
                            input int drop_bit);
    set_rx(big, 1'b0);
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == drop_bit) le4 = 1'b0;
      set_rx(big, b[i]);
      idle(CPB);
    end
    set_rx(big, stop_bit);
    idle(CPB);
    set_rx(big, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(3);
    wa4.delete(); wd4.delete(); wc4.delete();
    wa256.delete(); wd256.delete();
    wlong4 = 0; done_cyc4 = -1; pe_cyc4 = -1;
  endtask

  task automatic test_reset();
    rst = 1'b0; rx4 = 1'b1; rx256 = 1'b1; le4 = 1'b0; le256 = 1'b1;
    #3;
    total++; if (bus4.mem_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", bus4.mem_addr); end
    total++; if (bus4.mem_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bus4.mem_data); end
    total++; if (bus4.mem_wren !== 1'b0) begin bad++; $display("FAIL reset_wren got=%b exp=0", bus4.mem_wren); end
    total++; if ({pe4, ld4, fe4} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {pe4, ld4, fe4}); end
    total++; if ({pe256, ld256, fe256} !== 3'b000) begin bad++; $display("FAIL reset_flags256 got=%b exp=000", {pe256, ld256, fe256}); end
    idle(2);
    rst = 1'b1;
    idle(3);
  endtask

  task automatic test_load();
    logic [7:0] exp_b [4];
    exp_b = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    do_reset();
    le4 = 1'b1;
    for (int i = 0; i < 4; i++) send_frame(1'b0, exp_b[i], 1'b1, -1);
    idle(20);
    total++;
    if (wa4.size() !== 4) begin
      bad++; $display("FAIL load_count got=%0d exp=4", wa4.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (wa4[i] !== 8'(i)) begin bad++; $display("FAIL load_addr[%0d] got=%h exp=%h", i, wa4[i], 8'(i)); end
        total++; if (wd4[i] !== exp_b[i]) begin bad++; $display("FAIL load_data[%0d] got=%h exp=%h", i, wd4[i], exp_b[i]); end
      end
      total++; if (done_cyc4 !== wc4[3] + 1) begin bad++; $display("FAIL load_done_timing got=%0d exp=%0d", done_cyc4, wc4[3] + 1); end
      total++; if (pe_cyc4 !== wc4[3] + 1) begin bad++; $display("FAIL proc_en_timing got=%0d exp=%0d", pe_cyc4, wc4[3] + 1); end
    end
    total++; if (fe4 !== 1'b0) begin bad++; $display("FAIL load_frame_err got=%b exp=0", fe4); end
    total++; if (wlong4 !== 0) begin bad++; $display("FAIL wren_width long_pulses=%0d exp=0", wlong4); end
    send_frame(1'b0, 8'h66, 1'b1, -1);
    idle(20);
    total++; if (wa4.size() !== 4) begin bad++; $display("FAIL done_no_write got=%0d exp=4", wa4.size()); end
    total++; if ({ld4, pe4} !== 2'b11) begin bad++; $display("FAIL done_sticky got=%b exp=11", {ld4, pe4}); end
  endtask

  task automatic test_frame_err();
    do_reset();
    le4 = 1'b1;
    send_frame(1'b0, 8'h5A, 1'b0, -1);
    idle(30);
    total++; if (fe4 !== 1'b1) begin bad++; $display("FAIL ferr_set got=%b exp=1", fe4); end
    total++; if (wa4.size() !== 0) begin bad++; $display("FAIL ferr_no_write got=%0d exp=0", wa4.size()); end
    send_frame(1'b0, 8'h11, 1'b1, -1);
    idle(20);
    total++;
    if (wa4.size() !== 1) begin bad++; $display("FAIL ferr_next_count got=%0d exp=1", wa4.size()); end
    else if ({wa4[0], wd4[0]} !== 16'h0011) begin bad++; $display("FAIL ferr_next_write got=%h exp=0011", {wa4[0], wd4[0]}); end
    total++; if (fe4 !== 1'b1) begin bad++; $display("FAIL ferr_sticky got=%b exp=1", fe4); end
  endtask

  task automatic test_glitch();
    do_reset();
    le4 = 1'b1;
    rx4 = 1'b0;
    idle(2);
    rx4 = 1'b1;
    idle(20);
    total++; if (wa4.size() !== 0) begin bad++; $display("FAIL glitch_no_write got=%0d exp=0", wa4.size()); end
    total++; if (fe4 !== 1'b0) begin bad++; $display("FAIL glitch_ferr got=%b exp=0", fe4); end
    send_frame(1'b0, 8'h42, 1'b1, -1);
    idle(20);
    total++;
    if (wa4.size() !== 1) begin bad++; $display("FAIL glitch_recover_count got=%0d exp=1", wa4.size()); end
    else if ({wa4[0], wd4[0]} !== 16'h0042) begin bad++; $display("FAIL glitch_recover got=%h exp=0042", {wa4[0], wd4[0]}); end
  endtask

  task automatic test_load_en();
    do_reset();
    le4 = 1'b0;
    send_frame(1'b0, 8'h77, 1'b1, -1);
    idle(20);
    total++; if (wa4.size() !== 0) begin bad++; $display("FAIL le_low_no_write got=%0d exp=0", wa4.size()); end
    le4 = 1'b1;
    send_frame(1'b0, 8'h88, 1'b1, -1);
    idle(20);
    total++;
    if (wa4.size() !== 1) begin bad++; $display("FAIL le_high_count got=%0d exp=1", wa4.size()); end
    else if ({wa4[0], wd4[0]} !== 16'h0088) begin bad++; $display("FAIL le_high_write got=%h exp=0088", {wa4[0], wd4[0]}); end
    send_frame(1'b0, 8'hC3, 1'b1, 3);
    idle(20);
    total++;
    if (wa4.size() !== 2) begin bad++; $display("FAIL le_drop_count got=%0d exp=2", wa4.size()); end
    else if ({wa4[1], wd4[1]} !== 16'h01C3) begin bad++; $display("FAIL le_drop_write got=%h exp=01c3", {wa4[1], wd4[1]}); end
    send_frame(1'b0, 8'h99, 1'b1, -1);
    idle(20);
    total++; if (wa4.size() !== 2) begin bad++; $display("FAIL le_dropped_blocks got=%0d exp=2", wa4.size()); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    do_reset();
    le4 = 1'b1;
    send_frame(1'b0, 8'h12, 1'b1, -1);
    send_frame(1'b0, 8'h34, 1'b1, -1);
    idle(10);
    total++; if (wa4.size() !== 2) begin bad++; $display("FAIL mid_pre_count got=%0d exp=2", wa4.size()); end
    b = 8'h56;
    rx4 = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      rx4 = b[i];
      idle(CPB);
    end
    rst = 1'b0;
    #2;
    total++; if ({bus4.mem_addr, bus4.mem_data} !== 16'h0000) begin bad++; $display("FAIL mid_rst_bus got=%h exp=0000", {bus4.mem_addr, bus4.mem_data}); end
    total++; if ({bus4.mem_wren, pe4, ld4, fe4} !== 4'b0000) begin bad++; $display("FAIL mid_rst_flags got=%b exp=0000", {bus4.mem_wren, pe4, ld4, fe4}); end
    rx4 = 1'b1;
    idle(2);
    rst = 1'b1;
    idle(20);
    wa4.delete(); wd4.delete(); wc4.delete();
    send_frame(1'b0, 8'h9C, 1'b1, -1);
    idle(20);
    total++;
    if (wa4.size() !== 1) begin bad++; $display("FAIL mid_after_count got=%0d exp=1", wa4.size()); end
    else if ({wa4[0], wd4[0]} !== 16'h009C) begin bad++; $display("FAIL mid_after_write got=%h exp=009c", {wa4[0], wd4[0]}); end
  endtask

  task automatic test_depth256();
    int nbad;
    do_reset();
    le256 = 1'b1;
    for (int i = 0; i < 257; i++) send_frame(1'b1, 8'(i), 1'b1, -1);
    idle(20);
    total++;
    if (wa256.size() !== 256) begin
      bad++; $display("FAIL d256_count got=%0d exp=256", wa256.size());
    end else begin
      nbad = 0;
      for (int i = 0; i < 256; i++) begin
        total++;
        if (wa256[i] !== 8'(i) || wd256[i] !== 8'(i)) begin
          bad++; nbad++;
          if (nbad < 5) $display("FAIL d256_write[%0d] got=%h/%h exp=%h/%h", i, wa256[i], wd256[i], 8'(i), 8'(i));
        end
      end
      total++; if ({wa256[255], wd256[255]} !== 16'hFFFF) begin bad++; $display("FAIL d256_last got=%h exp=ffff", {wa256[255], wd256[255]}); end
    end
    total++; if ({pe256, ld256, fe256} !== 3'b110) begin bad++; $display("FAIL d256_flags got=%b exp=110", {pe256, ld256, fe256}); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_frame_err();
    test_glitch();
    test_load_en();
    test_reset_midframe();
    test_depth256();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_uart_loader.md
# dram_uart_loader

Serial boot loader that sits directly upstream of the processor's data memory. It receives 8N1 UART bytes on `rx` and writes them sequentially into DRAM through the DRAM's address, data and write-enable port. It holds the processor's `en` low until a full image of `DEPTH` bytes is stored, then releases it. After that it goes quiet until the next reset.

## Interface
- `CLKS_PER_BIT`, 434, CLK cycles per UART bit; must be ≥ 4.
- `DEPTH`, 256, number of bytes to load; range 1..256.
- `CLK`  in  1  memory clock; the same clock that drives DRAM.
- `rst`  in  1  asynchronous, active-low reset.
- `rx`  in  1  UART serial input; idles high.
- `load_en`  in  1  level signal; high allows new frames to start.
- `mem_addr`  out  8  DRAM write address.
- `mem_data`  out  8  DRAM write data.
- `mem_wren`  out  1  DRAM write strobe, one cycle per byte.
- `proc_en`  out  1  processor run enable.
- `load_done`  out  1  image complete; sticky.
- `frame_err`  out  1  stop-bit error seen; sticky.

## Operation
- `rx` passes through a 2-flop synchronizer; all decoding uses the synchronized value `rx_s`.
- States: IDLE, START, DATA, STOP, WRITE, DONE.
- IDLE: when `load_en`=1 and `rx_s`=0, load the bit timer with `CLKS_PER_BIT/2 - 1` and go to START. If `load_en`=0, stay in IDLE.
- START: when the timer expires, re-sample `rx_s`.
  - If 0: reload the timer with `CLKS_PER_BIT-1`, clear the bit index, go to DATA.
  - If 1: treat it as a glitch and return to IDLE. No error is flagged.
- DATA: sample `rx_s` on each timer expiry and shift it into the byte, LSB first. After bit 7, reload the timer and go to STOP.
- STOP: sample `rx_s` on timer expiry.
  - If 1: go to WRITE.
  - If 0: set `frame_err`, discard the byte, do not advance the address, return to IDLE.
- WRITE: one cycle.
  - `mem_wren`=1, `mem_addr`=current count, `mem_data`=received byte.
  - Count increments (9-bit counter).
  - If the new count equals `DEPTH`, go to DONE; otherwise go to IDLE.
- DONE: terminal state.
  - `load_done`=1 and `proc_en`=1.
  - `rx` and `load_en` are ignored.
  - No further writes occur.
  - Only `rst` leaves DONE.
- Dropping `load_en` during START, DATA or STOP does not abort the frame in progress; it only prevents the next frame from starting.
- `mem_addr` is the low 8 bits of the count. `DEPTH`=256 ends on address 255, so the address never wraps within a load.
- `mem_addr` and `mem_data` are registered and stable while `mem_wren`=1. Outside WRITE they hold their last values.

## Timing
- Reset state (asynchronous, `rst`=0):
  - State = IDLE; count = 0.
  - `mem_addr`=0, `mem_data`=0, `mem_wren`=0.
  - `proc_en`=0, `load_done`=0, `frame_err`=0.
  - Both synchronizer flops = 1.
- Reset mid-frame abandons the partial byte immediately. Bytes already written to DRAM are not erased.
- Synchronizer latency is 2 CLK cycles.
- The start bit is sampled `CLKS_PER_BIT/2` cycles after the falling edge appears on `rx_s`. Each following sample comes `CLKS_PER_BIT` cycles after the previous one.
- `mem_wren` rises on the cycle after the stop-bit sample and is high for exactly 1 cycle.
- `load_done` and `proc_en` rise in the cycle after the final WRITE. They stay high until reset.
- Back-to-back frames with no idle time between them (stop bit immediately followed by the next start bit) must be received without loss. WRITE costs one cycle, which is well inside half a bit.

## Test plan
- Reset, then `CLKS_PER_BIT`=8, `DEPTH`=4, `load_en`=1; send 0xA5, 0x3C, 0xFF, 0x00 back-to-back.
  - Expect 4 `mem_wren` pulses with (addr, data) = (0,A5), (1,3C), (2,FF), (3,00).
  - Expect `proc_en`=`load_done`=1 one cycle after the last write; `frame_err`=0.
- Send 0x5A with a low stop bit, then a valid 0x11.
  - Expect `frame_err`=1, no write for 0x5A, and 0x11 written at addr 0.
- Drive a 2-cycle low glitch on `rx`.
  - Expect a return to IDLE, no write, `frame_err`=0.
- Hold `load_en`=0 and send 0x77, then raise `load_en` and send 0x88.
  - Expect only 0x88 written, at addr 0.
  - In the same test, drop `load_en` during the data bits of a frame; expect that frame still written.
- Pulse `rst` low mid-frame after 2 good bytes.
  - Expect all outputs to return to their reset values immediately.
  - Expect the next good byte written at addr 0.
- With `DEPTH`=256, send 257 bytes with values i mod 256.
  - Expect the last write at addr 255 with data 0xFF.
  - Expect the 257th byte ignored and `proc_en`=1.
